// File: rtl/tl_pkg.sv
// Shared types and constants for the left-turn traffic-light controller.
// States, light encodings, dwell-counter width and small decode helpers.
package tl_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // A green
    S1 = 3'd1,  // A yellow
    S2 = 3'd2,  // A left
    S3 = 3'd3,  // A yellow2
    S4 = 3'd4,  // B green
    S5 = 3'd5,  // B yellow
    S6 = 3'd6,  // B left
    S7 = 3'd7   // B yellow2
  } tl_state_e;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_LEFT   = 2'b10;
  localparam logic [1:0] L_RED    = 2'b11;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
  } tl_lights_t;

  // Odd states are the yellow phases; they are timed, never sensor-held.
  function automatic logic is_yellow(tl_state_e s);
    return s[0];
  endfunction

  function automatic tl_state_e next_in_cycle(tl_state_e s);
    return tl_state_e'(s + 3'd1);
  endfunction

  // Light shown by the street that currently owns the intersection.
  function automatic logic [1:0] phase_light(logic [1:0] phase);
    logic [1:0] l;
    l = L_YELLOW;
    if (phase == 2'd0) l = L_GREEN;
    else if (phase == 2'd2) l = L_LEFT;
    return l;
  endfunction

  // State bit 2 selects which street owns the phase; the other street is red.
  function automatic tl_lights_t decode_lights(tl_state_e s);
    tl_lights_t d;
    if (s[2] == 1'b0) begin
      d.la = phase_light(s[1:0]);
      d.lb = L_RED;
    end else begin
      d.la = L_RED;
      d.lb = phase_light(s[1:0]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Dwell counter: counts cycles spent in the current FSM state.
// Synchronous clear and synchronous active-low reset; saturates at all-ones.
module tl_dwell_cnt
  import tl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignment so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tl_left_fsm.sv
// Moore FSM for a two-street intersection with protected left-turn phases.
// Define TL_MIN_GREEN_EN to enforce a MIN_GREEN-cycle minimum in green/left states.
module tl_left_fsm
  import tl_pkg::*;
#(
  parameter int YELLOW_CYC = 2,
  parameter int MIN_GREEN  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] state
);

  if (YELLOW_CYC < 1 || YELLOW_CYC > 15) begin : g_bad_yellow_cyc
    $error("tl_left_fsm: YELLOW_CYC must be in 1..15");
  end
  if (MIN_GREEN < 1 || MIN_GREEN > 15) begin : g_bad_min_green
    $error("tl_left_fsm: MIN_GREEN must be in 1..15");
  end

  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
`ifdef TL_MIN_GREEN_EN
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
`endif

  tl_state_e        r_state;
  tl_state_e        w_next_state;
  logic [CNT_W-1:0] w_dwell;
  logic             w_hold;
  logic             w_min_met;
  logic             w_state_change;
  tl_lights_t       w_lights;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S0;
    else          r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_hold = 1'b0;
    unique case (r_state)
      S0:      w_hold = Ta;
      S2:      w_hold = Tal;
      S4:      w_hold = Tb;
      S6:      w_hold = Tbl;
      default: w_hold = 1'b0;
    endcase
  end

`ifdef TL_MIN_GREEN_EN
  assign w_min_met = (w_dwell >= MIN_LAST);
`else
  assign w_min_met = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    if (is_yellow(r_state)) begin
      if (w_dwell == YEL_LAST) w_next_state = next_in_cycle(r_state);
    end else if (!w_hold && w_min_met) begin
      w_next_state = next_in_cycle(r_state);
    end
  end

  // The counter restarts on the edge that enters a new state, so it reads 0 there.
  assign w_state_change = (w_next_state != r_state);

  tl_dwell_cnt u_dwell_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_state_change),
    .o_cnt   (w_dwell)
  );

  assign w_lights = decode_lights(r_state);
  assign La       = w_lights.la;
  assign Lb       = w_lights.lb;
  assign state    = r_state;

endmodule
